wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Two-master, one-slave Wishbone classic-cycle arbiter that shares the CPU's single memory port between the instruction fetch unit (master 0) and the load/store unit (master 1). It latches each master's single-transfer request, grants the slave with round-robin fairness, replays the request to the slave as a clean one-cycle strobe, and routes ack/err/read data back to the owning master only. It sits between the CPU core and the memory/peripheral interconnect.

## Interface

- ADDR_WIDTH, 32, address width for masters and slave
- DATA_WIDTH, 32, data width for masters and slave
- TIMEOUT, 255, cycles in WAIT before abort (only with WB_ARB_TIMEOUT_EN); must be ≥ 1
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- i_m0_cyc, i_m0_stb, i_m0_we  in  1 each  master 0 (fetch) cycle/strobe/write-enable
- i_m0_addr  in  ADDR_WIDTH  master 0 address
- i_m0_data  in  DATA_WIDTH  master 0 write data
- o_m0_data  out  DATA_WIDTH  read data to master 0
- o_m0_ack, o_m0_err  out  1 each  termination to master 0
- i_m1_*, o_m1_*  same set for master 1 (load/store)
- o_s_cyc, o_s_stb, o_s_we  out  1 each  slave cycle/strobe/write-enable
- o_s_addr  out  ADDR_WIDTH  slave address
- o_s_data  out  DATA_WIDTH  slave write data
- i_s_data  in  DATA_WIDTH  slave read data
- i_s_ack, i_s_err  in  1 each  slave termination
- o_grant  out  2  one-hot owner of the slave (bit0 = m0), 0 when idle

## Operation

- Per-master request latch: when mX cyc&stb is high and pend_mX is 0, set pend_mX and capture addr/we/data. Later strobes while pending are ignored.
- pend_mX clears when mX cyc drops (abort before grant) or when its transfer terminates.
- States:
  - IDLE: no owner.
  - REQ: o_s_cyc=1, o_s_stb=1 for exactly one cycle.
  - WAIT: o_s_cyc=1, o_s_stb=0 until termination.
- IDLE → REQ when any pend_mX=1. Winner:
  - Only one pending: that master.
  - Both pending: the master that is not last_grant.
  - last_grant updates on entry to REQ.
- REQ → WAIT unconditionally, unless i_s_ack/i_s_err arrives in REQ; in that case go to IDLE.
- WAIT → IDLE on i_s_ack or i_s_err.
- Termination routing:
  - o_mX_ack = i_s_ack & o_grant[X] & (state ≠ IDLE) & i_mX_cyc; o_mX_err likewise from i_s_err.
  - o_mX_data = i_s_data when granted, else 0.
  - All three are combinational (zero added return latency).
  - Non-owner sees ack=err=0.
- Owner abort: owner's cyc low in REQ/WAIT → IDLE next edge, o_s_cyc drops, any ack in that cycle is not forwarded.
- Slave outputs o_s_addr/we/data are registered from the winner's latch on entry to REQ and held until IDLE.

## Timing

- Reset (async assert): state=IDLE, pend=0, last_grant=m1 (so m0 wins the first tie), o_s_cyc=o_s_stb=o_s_we=0, o_s_addr=o_s_data=0, o_grant=0, all master outputs 0.
- Minimum latency:
  - Master stb in cycle 0.
  - pend set at end of cycle 0.
  - o_s_cyc/o_s_stb high in cycle 2.
  - With a slave acking in cycle 3, master ack arrives in cycle 3.
- Back-to-back: after termination in cycle k, state is IDLE in cycle k+1. If the other master is pending, REQ is in cycle k+2.
- Simultaneous new request by mX and termination of mX's previous transfer in the same cycle: the new strobe is ignored (pend still set). The master must re-strobe, which Wishbone classic single-transfer masters do by restarting cyc.
- Both masters requesting continuously: strict alternation m0, m1, m0, …

## Configuration

- WB_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT with no i_s_ack/i_s_err, the arbiter asserts o_mX_err to the owner for one cycle (if the owner's cyc is still high) and returns to IDLE.
  - A slave ack arriving in that same cycle has priority: ack is forwarded, no err.
- WB_ARB_TIMEOUT_EN undefined: no counter; WAIT lasts indefinitely; o_mX_err driven only by i_s_err.

## Test plan

- Reset with both masters idle → all outputs 0, o_grant=0. m0 reads 0x100, slave acks 1 cycle after stb → o_s_stb high exactly in cycle 2, o_m0_ack in cycle 3 with o_m0_data=slave data, o_m1_ack=0 throughout.
- m0 and m1 strobe in the same cycle (addr 0x10 / 0x20) → m0 served first (o_s_addr=0x10), then m1 (o_s_addr=0x20) starting 2 cycles after m0's ack.
- m1 write, we=1, data 0xDEADBEEF to 0x40 → o_s_we=1, o_s_data=0xDEADBEEF held stable from REQ until ack.
- m1 drops cyc in WAIT, then slave acks → o_m1_ack stays 0, o_s_cyc low one cycle after the drop, state IDLE.
- WB_ARB_TIMEOUT_EN, TIMEOUT=8, slave never acks → o_m0_err pulses once 8 cycles after REQ entry, o_s_cyc drops next cycle. Without the macro, o_s_cyc stays high for 100+ cycles.
- Assert reset in WAIT → o_s_cyc, o_grant and pend clear immediately (asynchronous, no clock edge needed).

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master / one-slave Wishbone classic arbiter.
// Master 0 is instruction fetch and master 1 is load/store. The arbiter
// latches one single-transfer request per master and grants the slave
// round-robin. It replays the winning request as a one-cycle strobe. It
// routes ack/err/read data back to the owning master only.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   i_mX_cyc/stb/we/addr/data  master X request (X = 0, 1)
//   o_mX_data/ack/err          master X response (combinational from slave)
//   o_s_cyc/stb/we/addr/data   slave request
//   i_s_data/ack/err           slave response
//   o_grant                    one-hot current owner (bit0 = m0), 0 when idle
//
// Optional feature: define WB_ARB_TIMEOUT_EN to abort a transfer with an
// error to the owner once TIMEOUT cycles pass in REQ/WAIT without a slave
// termination.
module wb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_m0_cyc,
  input  logic                  i_m0_stb,
  input  logic                  i_m0_we,
  input  logic [ADDR_WIDTH-1:0] i_m0_addr,
  input  logic [DATA_WIDTH-1:0] i_m0_data,
  output logic [DATA_WIDTH-1:0] o_m0_data,
  output logic                  o_m0_ack,
  output logic                  o_m0_err,
  input  logic                  i_m1_cyc,
  input  logic                  i_m1_stb,
  input  logic                  i_m1_we,
  input  logic [ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [DATA_WIDTH-1:0] i_m1_data,
  output logic [DATA_WIDTH-1:0] o_m1_data,
  output logic                  o_m1_ack,
  output logic                  o_m1_err,
  output logic                  o_s_cyc,
  output logic                  o_s_stb,
  output logic                  o_s_we,
  output logic [ADDR_WIDTH-1:0] o_s_addr,
  output logic [DATA_WIDTH-1:0] o_s_data,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  input  logic                  i_s_ack,
  input  logic                  i_s_err,
  output logic [1:0]            o_grant
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [1:0]            pend_r;
  logic [1:0]            lat_we_r;
  logic [ADDR_WIDTH-1:0] lat_addr_r [2];
  logic [DATA_WIDTH-1:0] lat_data_r [2];
  // Index of the master granted most recently; also the current owner while busy.
  logic                  last_grant_r;
  logic                  s_we_r;
  logic [ADDR_WIDTH-1:0] s_addr_r;
  logic [DATA_WIDTH-1:0] s_data_r;

  logic [1:0]            m_cyc_s;
  logic [1:0]            m_stb_s;
  logic [1:0]            m_we_s;
  logic [ADDR_WIDTH-1:0] m_addr_s [2];
  logic [DATA_WIDTH-1:0] m_data_s [2];
  logic                  busy_s;
  logic                  start_s;
  logic                  winner_s;
  logic [1:0]            grant_s;
  logic                  owner_cyc_s;
  logic                  timeout_s;
  logic                  term_s;
  logic                  abort_s;

  assign m_cyc_s     = {i_m1_cyc, i_m0_cyc};
  assign m_stb_s     = {i_m1_stb, i_m0_stb};
  assign m_we_s      = {i_m1_we, i_m0_we};
  assign m_addr_s[0] = i_m0_addr;
  assign m_addr_s[1] = i_m1_addr;
  assign m_data_s[0] = i_m0_data;
  assign m_data_s[1] = i_m1_data;

  assign busy_s      = (state_r != ST_IDLE);
  assign start_s     = (state_r == ST_IDLE) && (pend_r != 2'b00);
  assign grant_s     = busy_s ? (last_grant_r ? 2'b10 : 2'b01) : 2'b00;
  assign owner_cyc_s = last_grant_r ? i_m1_cyc : i_m0_cyc;
  assign term_s      = busy_s && (i_s_ack || i_s_err || timeout_s);
  assign abort_s     = busy_s && !owner_cyc_s;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_r;

  // Transfer age counter: zero in the REQ cycle, saturates at TIMEOUT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (start_s) begin
      cnt_r <= '0;
    end else if (busy_s && (cnt_r != TO_VAL)) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // A slave termination in the same cycle wins over the timeout.
  assign timeout_s = busy_s && (cnt_r == TO_VAL) && !i_s_ack && !i_s_err;
`else
  assign timeout_s = 1'b0;
`endif

  // Round-robin pick: on a tie the master not granted last wins.
  always_comb begin
    winner_s = 1'b0;
    if (pend_r == 2'b11) begin
      winner_s = ~last_grant_r;
    end else if (pend_r[1]) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pend_r != 2'b00) state_s = ST_REQ;
        else                 state_s = ST_IDLE;
      end
      ST_REQ: begin
        if (term_s || abort_s) state_s = ST_IDLE;
        else                   state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (term_s || abort_s) state_s = ST_IDLE;
        else                   state_s = ST_WAIT;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Per-master request latch. Strobes seen while a request is pending are
  // dropped, including one that coincides with the terminating cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_r   <= 2'b00;
      lat_we_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        lat_addr_r[i] <= '0;
        lat_data_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pend_r[i]) begin
          if (!m_cyc_s[i] || (term_s && grant_s[i])) pend_r[i] <= 1'b0;
        end else if (m_cyc_s[i] && m_stb_s[i]) begin
          pend_r[i]     <= 1'b1;
          lat_we_r[i]   <= m_we_s[i];
          lat_addr_r[i] <= m_addr_s[i];
          lat_data_r[i] <= m_data_s[i];
        end
      end
    end
  end

  // Owner and slave request registers, loaded on entry to REQ and held after.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_r <= 1'b1;
      s_we_r       <= 1'b0;
      s_addr_r     <= '0;
      s_data_r     <= '0;
    end else if (start_s) begin
      last_grant_r <= winner_s;
      s_we_r       <= lat_we_r[winner_s];
      s_addr_r     <= lat_addr_r[winner_s];
      s_data_r     <= lat_data_r[winner_s];
    end
  end

  assign o_s_cyc  = busy_s;
  assign o_s_stb  = (state_r == ST_REQ);
  assign o_s_we   = s_we_r;
  assign o_s_addr = s_addr_r;
  assign o_s_data = s_data_r;
  assign o_grant  = grant_s;

  // Terminations reach only the owner, and only while it still holds cyc.
  assign o_m0_ack  = i_s_ack && grant_s[0] && i_m0_cyc;
  assign o_m1_ack  = i_s_ack && grant_s[1] && i_m1_cyc;
  assign o_m0_err  = (i_s_err || timeout_s) && grant_s[0] && i_m0_cyc;
  assign o_m1_err  = (i_s_err || timeout_s) && grant_s[1] && i_m1_cyc;
  assign o_m0_data = grant_s[0] ? i_s_data : '0;
  assign o_m1_data = grant_s[1] ? i_s_data : '0;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter. It uses directed scenarios plus
// randomized request rounds. The expected slave requests and master
// responses are queued when stimulus is issued. A monitor pops and compares
// them whenever the DUT strobes the slave or terminates a master.
module tb_wb_arbiter;

  typedef struct packed {
    logic        owner;
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } sreq_t;

  typedef struct packed {
    logic        err;
    logic        chk;
    logic [31:0] data;
  } mrsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_we [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata [2];
  logic [31:0] o_m0_data, o_m1_data, o_s_addr, o_s_data;
  logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
  logic        o_s_cyc, o_s_stb, o_s_we;
  logic [1:0]  o_grant;
  logic        s_ack, s_err;
  logic [31:0] s_rdata;

  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc_cnt = 0;
  int    start_cyc [2];
  int    stb_log [$];
  int    ack_log [$];
  int    err_log [$];
  sreq_t s_exp_q [$];
  mrsp_t m_exp_q0 [$];
  mrsp_t m_exp_q1 [$];
  bit    last_served = 1'b1;
  bit    slave_hold = 1'b0;
  int    slave_delay = -1;
  logic [31:0] h_addr, h_data;
  logic        h_we;

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  wb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .i_m0_cyc(m_cyc[0]), .i_m0_stb(m_stb[0]), .i_m0_we(m_we[0]),
    .i_m0_addr(m_addr[0]), .i_m0_data(m_wdata[0]),
    .o_m0_data(o_m0_data), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
    .i_m1_cyc(m_cyc[1]), .i_m1_stb(m_stb[1]), .i_m1_we(m_we[1]),
    .i_m1_addr(m_addr[1]), .i_m1_data(m_wdata[1]),
    .o_m1_data(o_m1_data), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
    .o_s_addr(o_s_addr), .o_s_data(o_s_data),
    .i_s_data(s_rdata), .i_s_ack(s_ack), .i_s_err(s_err),
    .o_grant(o_grant)
  );

  function automatic logic [31:0] resp_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic resp_err(input logic [31:0] a);
    return (a[7:4] == 4'hF);
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc_cnt);
  endtask

  task automatic sample();
    @(negedge clk);
    #2;
  endtask

  // Slave model: answers each strobe after 0..3 cycles unless held off.
  initial begin
    logic [31:0] a;
    int          d;
    s_ack = 1'b0; s_err = 1'b0; s_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (o_s_stb && !slave_hold && reset) begin
        a = o_s_addr;
        d = (slave_delay < 0) ? int'($urandom_range(0, 3)) : slave_delay;
        if (d != 0) begin
          repeat (d) @(posedge clk);
          #1;
        end
        s_rdata = resp_data(a);
        if (resp_err(a)) s_err = 1'b1;
        else             s_ack = 1'b1;
        @(posedge clk);
        #1;
        s_ack = 1'b0; s_err = 1'b0;
      end
    end
  end

  task automatic mon_rsp(input int x, input logic ack, input logic err,
                         input logic [31:0] data, input logic gnt);
    mrsp_t e;
    bit    empty;
    if (ack || err) begin
      if (ack) ack_log.push_back(cyc_cnt);
      else     err_log.push_back(cyc_cnt);
      check($sformatf("m%0d_term_owner", x), gnt, 1'b1);
      check($sformatf("m%0d_ack_and_err", x), ack & err, 1'b0);
      empty = (x == 0) ? (m_exp_q0.size() == 0) : (m_exp_q1.size() == 0);
      if (empty) begin
        fail_now($sformatf("m%0d_unexpected_termination", x));
      end else begin
        e = (x == 0) ? m_exp_q0.pop_front() : m_exp_q1.pop_front();
        check($sformatf("m%0d_err", x), err, e.err);
        if (e.chk) check($sformatf("m%0d_rdata", x), data, e.data);
      end
    end
  endtask

  // Monitor: compares slave requests, hold stability and master terminations.
  initial begin
    sreq_t e;
    forever begin
      sample();
      if (reset) begin
        check("grant_vs_cyc", (o_grant != 2'b00), o_s_cyc);
        if (o_s_stb) begin
          stb_log.push_back(cyc_cnt);
          h_addr = o_s_addr; h_data = o_s_data; h_we = o_s_we;
          if (s_exp_q.size() == 0) begin
            fail_now("unexpected_slave_stb");
          end else begin
            e = s_exp_q.pop_front();
            check("s_grant", o_grant, e.owner ? 2'b10 : 2'b01);
            check("s_addr", o_s_addr, e.addr);
            check("s_we", o_s_we, e.we);
            check("s_data", o_s_data, e.data);
          end
        end else if (o_s_cyc) begin
          check("s_hold", {o_s_addr, o_s_data, o_s_we}, {h_addr, h_data, h_we});
        end
        mon_rsp(0, o_m0_ack, o_m0_err, o_m0_data, o_grant[0]);
        mon_rsp(1, o_m1_ack, o_m1_err, o_m1_data, o_grant[1]);
      end
    end
  end

  // One classic single transfer: raise cyc/stb, wait for the termination, release.
  task automatic master_txn(input int x, input logic [31:0] a, input logic we,
                            input logic [31:0] d, input int dly);
    bit done;
    int n;
    repeat (dly) @(posedge clk);
    @(posedge clk);
    #1;
    m_cyc[x] = 1'b1; m_stb[x] = 1'b1; m_we[x] = we; m_addr[x] = a; m_wdata[x] = d;
    start_cyc[x] = cyc_cnt;
    done = 1'b0;
    n = 0;
    while (!done && n < 300) begin
      sample();
      done = (x == 0) ? (o_m0_ack || o_m0_err) : (o_m1_ack || o_m1_err);
      n++;
    end
    if (!done) fail_now($sformatf("m%0d_no_termination", x));
    @(posedge clk);
    #1;
    m_cyc[x] = 1'b0; m_stb[x] = 1'b0;
  endtask

  // Expected outcome of one transfer, queued for the monitor.
  task automatic expect_txn(input bit x, input logic [31:0] a, input logic we, input logic [31:0] d);
    mrsp_t r;
    s_exp_q.push_back('{owner: x, addr: a, we: we, data: d});
    r = '{err: resp_err(a), chk: 1'b1, data: resp_data(a)};
    if (x == 1'b0) m_exp_q0.push_back(r);
    else           m_exp_q1.push_back(r);
  endtask

  // Random round: m0, m1 or both, with m1 starting one cycle before, with or after m0.
  task automatic run_round();
    int          pat;
    int          off;
    bit          first;
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic        w [2];
    pat = $urandom_range(1, 3);
    off = (pat == 3) ? int'($urandom_range(0, 2)) - 1 : 0;
    for (int i = 0; i < 2; i++) begin
      a[i] = $urandom();
      d[i] = $urandom();
      w[i] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) a[i][7:4] = 4'hF;
    end
    if (pat == 3) begin
      if (off > 0)      first = 1'b0;
      else if (off < 0) first = 1'b1;
      else              first = ~last_served;
      expect_txn(first, a[first], w[first], d[first]);
      expect_txn(~first, a[~first], w[~first], d[~first]);
      last_served = ~first;
      fork
        master_txn(0, a[0], w[0], d[0], (off < 0) ? 1 : 0);
        master_txn(1, a[1], w[1], d[1], (off > 0) ? 1 : 0);
      join
    end else begin
      first = (pat == 2);
      expect_txn(first, a[first], w[first], d[first]);
      last_served = first;
      master_txn(first, a[first], w[first], d[first], 0);
    end
    repeat ($urandom_range(1, 2)) @(posedge clk);
  endtask

  task automatic clear_logs();
    stb_log.delete(); ack_log.delete(); err_log.delete();
  endtask

  initial begin
    int n0;
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
      m_addr[i] = 32'h0; m_wdata[i] = 32'h0;
    end
    reset = 1'b0;
    #12;
    check("rst_ctrl", {o_s_cyc, o_s_stb, o_s_we, o_grant, o_m0_ack, o_m0_err, o_m1_ack, o_m1_err}, 9'h0);
    check("rst_s_bus", {o_s_addr, o_s_data}, 64'h0);
    check("rst_m_data", {o_m0_data, o_m1_data}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) sample();
    check("idle_ctrl", {o_s_cyc, o_grant}, 3'h0);

    // m0 read at minimum latency: stb two cycles after request, ack one later.
    clear_logs();
    slave_delay = 1;
    expect_txn(1'b0, 32'h100, 1'b0, 32'h1111_2222);
    last_served = 1'b0;
    master_txn(0, 32'h100, 1'b0, 32'h1111_2222, 0);
    check("lat_stb", stb_log[0], start_cyc[0] + 2);
    check("lat_ack", ack_log[0], start_cyc[0] + 3);
    repeat (2) @(posedge clk);

    // m1 write held stable for several cycles until the ack.
    slave_delay = 3;
    expect_txn(1'b1, 32'h40, 1'b1, 32'hDEAD_BEEF);
    last_served = 1'b1;
    master_txn(1, 32'h40, 1'b1, 32'hDEAD_BEEF, 0);
    repeat (2) @(posedge clk);

    // Simultaneous requests: m0 first, m1 strobed two cycles after m0's ack.
    clear_logs();
    slave_delay = 1;
    expect_txn(1'b0, 32'h10, 1'b0, 32'h0);
    expect_txn(1'b1, 32'h20, 1'b0, 32'h0);
    last_served = 1'b1;
    fork
      master_txn(0, 32'h10, 1'b0, 32'h0, 0);
      master_txn(1, 32'h20, 1'b0, 32'h0, 0);
    join
    check("b2b_gap", stb_log[1], ack_log[0] + 2);
    repeat (2) @(posedge clk);

    // Owner abort in WAIT: a coinciding slave ack must not reach m1.
    slave_hold = 1'b1;
    s_exp_q.push_back('{owner: 1'b1, addr: 32'h80, we: 1'b0, data: 32'h5});
    last_served = 1'b1;
    @(posedge clk);
    #1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_addr[1] = 32'h80; m_wdata[1] = 32'h5;
    repeat (4) @(posedge clk);
    #1;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    s_rdata = 32'hABCD_0123; s_ack = 1'b1;
    sample();
    check("abort_no_ack", o_m1_ack, 1'b0);
    check("abort_cyc_still", o_s_cyc, 1'b1);
    @(posedge clk);
    #1;
    s_ack = 1'b0;
    sample();
    check("abort_cyc_drop", {o_s_cyc, o_grant}, 3'h0);
    slave_hold = 1'b0;
    repeat (2) @(posedge clk);

    // Silent slave.
    slave_hold = 1'b1;
    clear_logs();
`ifdef WB_ARB_TIMEOUT_EN
    s_exp_q.push_back('{owner: 1'b0, addr: 32'h300, we: 1'b0, data: 32'h0});
    m_exp_q0.push_back('{err: 1'b1, chk: 1'b0, data: 32'h0});
    last_served = 1'b0;
    master_txn(0, 32'h300, 1'b0, 32'h0, 0);
    check("to_err_cycle", err_log[0], start_cyc[0] + 10);
    sample();
    check("to_cyc_drop", o_s_cyc, 1'b0);
    repeat (4) @(posedge clk);
    check("to_err_once", err_log.size(), 1);
`else
    s_exp_q.push_back('{owner: 1'b0, addr: 32'h300, we: 1'b0, data: 32'h0});
    last_served = 1'b0;
    @(posedge clk);
    #1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 32'h300; m_wdata[0] = 32'h0;
    repeat (120) @(posedge clk);
    sample();
    check("noack_cyc_held", {o_s_cyc, o_s_stb}, 2'b10);
    check("noack_no_err", err_log.size(), 0);
    @(posedge clk);
    #1;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    repeat (2) sample();
    check("noack_abort_idle", o_s_cyc, 1'b0);
`endif
    repeat (2) @(posedge clk);

    // Reset in WAIT clears the bus at once; cyc stays up without stb afterwards.
    s_exp_q.push_back('{owner: 1'b0, addr: 32'h200, we: 1'b1, data: 32'h77});
    @(posedge clk);
    #1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_addr[0] = 32'h200; m_wdata[0] = 32'h77;
    repeat (4) @(posedge clk);
    #3;
    check("pre_rst_busy", o_s_cyc, 1'b1);
    reset = 1'b0;
    m_stb[0] = 1'b0;
    #1;
    check("async_rst", {o_s_cyc, o_s_stb, o_grant}, 4'h0);
    @(negedge clk);
    reset = 1'b1;
    last_served = 1'b1;
    n0 = 0;
    for (int i = 0; i < 4; i++) begin
      sample();
      if (o_s_cyc) n0++;
    end
    check("rst_pend_clear", n0, 0);
    @(posedge clk);
    #1;
    m_cyc[0] = 1'b0;
    slave_hold = 1'b0;
    repeat (2) @(posedge clk);

    // Randomized rounds.
    slave_delay = -1;
    for (int r = 0; r < 40; r++) run_round();

    repeat (4) @(posedge clk);
    check("s_exp_drained", s_exp_q.size(), 0);
    check("m0_exp_drained", m_exp_q0.size(), 0);
    check("m1_exp_drained", m_exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired (cycle %0d)", cyc_cnt);
    $fatal(1, "watchdog");
  end

endmodule
